// File: rtl/dma_scheduler_if.sv
// Bundle of requester handshakes and DMA engine configuration seen by dma_scheduler.
// master is the scheduler's view; slave is the requesters' and DMA engine's view.
interface dma_scheduler_if;
    logic        req0_valid;
    logic [31:0] req0_src;
    logic [31:0] req0_dst;
    logic [31:0] req0_len;
    logic        req0_ready;
    logic        done0;
    logic        err0;

    logic        req1_valid;
    logic [31:0] req1_src;
    logic [31:0] req1_dst;
    logic [31:0] req1_len;
    logic        req1_ready;
    logic        done1;
    logic        err1;

    logic        DMAEN;
    logic [31:0] DMASRC;
    logic [31:0] DMADST;
    logic [31:0] DMALEN;
    logic        DMA_interrupt;
    logic        busy;
    logic        owner;

    modport master (
        input  req0_valid, req0_src, req0_dst, req0_len,
        output req0_ready, done0, err0,
        input  req1_valid, req1_src, req1_dst, req1_len,
        output req1_ready, done1, err1,
        output DMAEN, DMASRC, DMADST, DMALEN,
        input  DMA_interrupt,
        output busy, owner
    );

    modport slave (
        output req0_valid, req0_src, req0_dst, req0_len,
        input  req0_ready, done0, err0,
        output req1_valid, req1_src, req1_dst, req1_len,
        input  req1_ready, done1, err1,
        input  DMAEN, DMASRC, DMADST, DMALEN,
        output DMA_interrupt,
        input  busy, owner
    );
endinterface

// File: rtl/dma_scheduler.sv
// Two-requester round-robin front end for a single DMA engine: accepts one
// descriptor at a time, runs it with a timeout watchdog and reports done/err.
module dma_scheduler #(
    parameter logic [15:0] TIMEOUT = 16'd65535
) (
    input  logic clk,
    input  logic rst,
    dma_scheduler_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] CLEAR = 2'd3;

    localparam logic [15:0] LAST_COUNT = TIMEOUT - 16'd1;

    logic [1:0]  state;
    logic        last_grant;
    logic [15:0] run_count;
    logic        owner_q;
    logic        status_err;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [31:0] len_q;

    logic        grant;
    logic        accept;
    logic [31:0] sel_src;
    logic [31:0] sel_dst;
    logic [31:0] sel_len;

    // On a tie the requester not served last wins; a lone valid always wins.
    always_comb begin
        grant   = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
        accept  = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
        sel_src = grant ? bus.req1_src : bus.req0_src;
        sel_dst = grant ? bus.req1_dst : bus.req0_dst;
        sel_len = grant ? bus.req1_len : bus.req0_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            run_count  <= 16'd0;
            owner_q    <= 1'b0;
            status_err <= 1'b0;
            src_q      <= 32'd0;
            dst_q      <= 32'd0;
            len_q      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        src_q      <= sel_src;
                        dst_q      <= sel_dst;
                        len_q      <= sel_len;
                        owner_q    <= grant;
                        last_grant <= grant;
                        status_err <= 1'b0;
                        state      <= (sel_len == 32'd0) ? CLEAR : LOAD;
                    end
                end
                LOAD: begin
                    run_count <= 16'd0;
                    state     <= RUN;
                end
                RUN: begin
                    // A completion arriving on the final watchdog cycle still counts as success.
                    if (bus.DMA_interrupt) begin
                        status_err <= 1'b0;
                        state      <= CLEAR;
                    end else if (run_count == LAST_COUNT) begin
                        status_err <= 1'b1;
                        state      <= CLEAR;
                    end else begin
                        run_count <= run_count + 16'd1;
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = accept && !grant;
    assign bus.req1_ready = accept && grant;

    assign bus.done0 = (state == CLEAR) && !status_err && !owner_q;
    assign bus.done1 = (state == CLEAR) && !status_err && owner_q;
    assign bus.err0  = (state == CLEAR) && status_err && !owner_q;
    assign bus.err1  = (state == CLEAR) && status_err && owner_q;

    assign bus.DMAEN  = (state == RUN);
    assign bus.DMASRC = src_q;
    assign bus.DMADST = dst_q;
    assign bus.DMALEN = len_q;
    assign bus.busy   = (state != IDLE);
    assign bus.owner  = owner_q;
endmodule

// File: tb/tb_dma_scheduler.sv
// Bench for dma_scheduler: directed scenarios with literal expectations, then
// random traffic checked every cycle against a job-timeline reference model.
module tb_dma_scheduler;
    localparam int TMO = 8;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    dma_scheduler_if bus ();

    dma_scheduler #(.TIMEOUT(16'(TMO))) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
    task automatic apply_stimulus(input logic r,
                                  input logic v0, input logic [31:0] s0, input logic [31:0] d0,
                                  input logic [31:0] l0,
                                  input logic v1, input logic [31:0] s1, input logic [31:0] d1,
                                  input logic [31:0] l1,
                                  input logic intr);
        @(posedge clk);
        #1;
        rst               = r;
        bus.req0_valid    = v0;
        bus.req0_src      = s0;
        bus.req0_dst      = d0;
        bus.req0_len      = l0;
        bus.req1_valid    = v1;
        bus.req1_src      = s1;
        bus.req1_dst      = d1;
        bus.req1_len      = l1;
        bus.DMA_interrupt = intr;
        #2;
    endtask

    task automatic idle_cycle(input logic intr);
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, intr);
    endtask

    // Reference model: a job is described by its acceptance cycle and, once
    // known, the cycle of its completion report; everything follows from those.
    int          cyc = 0;
    bit          seen_reset = 0;
    bit          m_active = 0;
    int          m_acc = 0;
    int          m_clr = -1;
    bit          m_err = 0;
    bit          m_owner = 0;
    bit          m_last = 1;
    logic [31:0] m_src = 0;
    logic [31:0] m_dst = 0;
    logic [31:0] m_len = 0;

    always @(negedge clk) begin : model
        bit g;
        bit in_run;
        bit in_clr;
        logic [31:0] c_src;
        logic [31:0] c_dst;
        logic [31:0] c_len;
        g      = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
        in_clr = m_active && (cyc == m_clr);
        in_run = m_active && (m_clr < 0) && (cyc >= m_acc + 2);
        if (seen_reset) begin
            check_output("ready0", bus.req0_ready, !m_active && bus.req0_valid && !g);
            check_output("ready1", bus.req1_ready, !m_active && bus.req1_valid && g);
            check_output("done0", bus.done0, in_clr && !m_err && !m_owner);
            check_output("done1", bus.done1, in_clr && !m_err && m_owner);
            check_output("err0", bus.err0, in_clr && m_err && !m_owner);
            check_output("err1", bus.err1, in_clr && m_err && m_owner);
            check_output("DMAEN", bus.DMAEN, in_run);
            check_output("busy", bus.busy, m_active);
            check_output("owner", bus.owner, m_owner);
            check_output("DMASRC", bus.DMASRC, m_src);
            check_output("DMADST", bus.DMADST, m_dst);
            check_output("DMALEN", bus.DMALEN, m_len);
        end
        if (rst) begin
            seen_reset = 1;
            m_active   = 0;
            m_last     = 1;
            m_owner    = 0;
            m_clr      = -1;
            m_src      = 0;
            m_dst      = 0;
            m_len      = 0;
        end else if (!m_active) begin
            if (bus.req0_valid || bus.req1_valid) begin
                c_src    = g ? bus.req1_src : bus.req0_src;
                c_dst    = g ? bus.req1_dst : bus.req0_dst;
                c_len    = g ? bus.req1_len : bus.req0_len;
                m_active = 1;
                m_acc    = cyc;
                m_owner  = g;
                m_last   = g;
                m_src    = c_src;
                m_dst    = c_dst;
                m_len    = c_len;
                m_err    = 0;
                m_clr    = (c_len == 0) ? cyc + 1 : -1;
            end
        end else if (in_clr) begin
            m_active = 0;
        end else if (in_run) begin
            if (bus.DMA_interrupt) begin
                m_clr = cyc + 1;
                m_err = 0;
            end else if (cyc - (m_acc + 2) == TMO - 1) begin
                m_clr = cyc + 1;
                m_err = 1;
            end
        end
        cyc++;
    end

    initial begin : stim
        int en_cnt;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_src = 0; bus.req0_dst = 0; bus.req0_len = 0;
        bus.req1_valid = 1'b0; bus.req1_src = 0; bus.req1_dst = 0; bus.req1_len = 0;
        bus.DMA_interrupt = 1'b0;

        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_cycle(0);
        check_output("rst_busy", bus.busy, 0);
        check_output("rst_DMAEN", bus.DMAEN, 0);
        check_output("rst_DMASRC", bus.DMASRC, 0);

        // Both requesters always valid with zero-length jobs: grants alternate 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(0, 1, 32'h10 + k, 32'h20 + k, 0, 1, 32'h30 + k, 32'h40 + k, 0, 0);
            check_output("tie_ready0", bus.req0_ready, (k % 2) == 0);
            check_output("tie_ready1", bus.req1_ready, (k % 2) == 1);
            apply_stimulus(0, 1, 32'h10 + k, 32'h20 + k, 0, 1, 32'h30 + k, 32'h40 + k, 0, 0);
            check_output("tie_done0", bus.done0, (k % 2) == 0);
            check_output("tie_done1", bus.done1, (k % 2) == 1);
            check_output("zero_DMAEN", bus.DMAEN, 0);
            check_output("tie_ready_clear", bus.req0_ready | bus.req1_ready, 0);
        end

        // Single job: interrupt on cycle 7 after acceptance.
        apply_stimulus(0, 1, 32'h1000, 32'h2000, 4, 0, 0, 0, 0, 0);
        check_output("single_ready0", bus.req0_ready, 1);
        idle_cycle(0);
        check_output("load_DMAEN", bus.DMAEN, 0);
        check_output("load_DMASRC", bus.DMASRC, 32'h1000);
        check_output("load_DMALEN", bus.DMALEN, 4);
        for (int k = 2; k <= 6; k++) begin
            idle_cycle(0);
            check_output("single_DMAEN", bus.DMAEN, 1);
        end
        idle_cycle(1);
        check_output("single_DMAEN_c7", bus.DMAEN, 1);
        idle_cycle(0);
        check_output("single_done0", bus.done0, 1);
        check_output("single_DMAEN_c8", bus.DMAEN, 0);
        idle_cycle(0);
        check_output("single_busy_c9", bus.busy, 0);
        check_output("single_DMADST_hold", bus.DMADST, 32'h2000);

        // Timeout: no interrupt, run lasts exactly TMO cycles then err0.
        apply_stimulus(0, 1, 32'h5000, 32'h6000, 5, 0, 0, 0, 0, 0);
        idle_cycle(0);
        en_cnt = 0;
        for (int k = 0; k < TMO; k++) begin
            idle_cycle(0);
            if (bus.DMAEN) en_cnt++;
        end
        check_output("tmo_run_cycles", en_cnt, TMO);
        idle_cycle(0);
        check_output("tmo_err0", bus.err0, 1);
        check_output("tmo_done0", bus.done0, 0);
        idle_cycle(0);
        check_output("tmo_busy", bus.busy, 0);

        // Interrupt on the last run cycle beats the timeout.
        apply_stimulus(0, 1, 32'h7000, 32'h8000, 9, 0, 0, 0, 0, 0);
        idle_cycle(0);
        for (int k = 0; k < TMO - 1; k++) idle_cycle(0);
        idle_cycle(1);
        idle_cycle(0);
        check_output("simul_done0", bus.done0, 1);
        check_output("simul_err0", bus.err0, 0);

        // Reset during RUN of a requester 1 job.
        idle_cycle(0);
        apply_stimulus(0, 0, 0, 0, 0, 1, 32'hAAAA, 32'hBBBB, 50, 0);
        check_output("rr_ready1", bus.req1_ready, 1);
        for (int k = 0; k < 4; k++) idle_cycle(0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("rr_DMAEN_before", bus.DMAEN, 1);
        check_output("rr_owner_before", bus.owner, 1);
        idle_cycle(0);
        check_output("rr_DMAEN_after", bus.DMAEN, 0);
        check_output("rr_busy_after", bus.busy, 0);
        check_output("rr_owner_after", bus.owner, 0);
        check_output("rr_DMASRC_after", bus.DMASRC, 0);
        check_output("rr_pulses", {bus.done0, bus.done1, bus.err0, bus.err1}, 0);
        apply_stimulus(0, 1, 32'hC000, 32'hD000, 3, 0, 0, 0, 0, 0);
        check_output("rr_next_ready0", bus.req0_ready, 1);
        idle_cycle(0);
        idle_cycle(1);
        idle_cycle(0);
        check_output("rr_next_done0", bus.done0, 1);
        idle_cycle(0);

        // Random traffic, checked by the model on every cycle.
        for (int k = 0; k < 3000; k++) begin
            apply_stimulus($urandom_range(0, 299) == 0,
                           1'($urandom_range(0, 1)), $urandom, $urandom,
                           ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 100)),
                           1'($urandom_range(0, 1)), $urandom, $urandom,
                           ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 100)),
                           $urandom_range(0, 4) == 0);
        end
        idle_cycle(0);
        idle_cycle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
